// File: rtl/pc_trap_unit_pkg.sv
// Shared definitions for the PC / trap unit: controller states, default
// vector addresses and the cause-field width helper.
package pc_trap_unit_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } trap_state_e;

  localparam int unsigned DEF_RESET_VEC = 32'd0;
  localparam int unsigned DEF_TRAP_VEC  = 32'd248;

  // Width of the cause index; a single fault line still needs one bit.
  function automatic int cause_w(input int n_fault);
    return (n_fault > 1) ? $clog2(n_fault) : 1;
  endfunction

endpackage

// File: rtl/pc_fault_prio.sv
// Combinational fixed-priority encoder: bit 0 of fault is the most urgent.
// Reports whether any request is present and the index of the winner.
module pc_fault_prio
  import pc_trap_unit_pkg::*;
#(
  parameter int N_FAULT = 4
) (
  input  logic [N_FAULT-1:0]          fault,
  output logic                        valid,
  output logic [cause_w(N_FAULT)-1:0] index
);

  localparam int IDX_W = cause_w(N_FAULT);

  // Scan from the lowest-priority line down so the lowest set index wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    valid = 1'b0;
    index = '0;
    for (int i = N_FAULT - 1; i >= 0; i--) begin
      if (fault[i]) begin
        valid = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/pc_trap_unit.sv
// Program counter register with a single-level trap controller.
// In RUN the PC follows the fetch candidate (or holds on stall); any fault
// request diverts to TRAP_VEC, saving the faulting PC and the fault index.
// In TRAP further faults are ignored; fault_ack_i returns to the saved PC.
module pc_trap_unit
  import pc_trap_unit_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              N_FAULT      = 4,
  parameter logic [XLEN-1:0] RESET_VEC    = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC     = XLEN'(DEF_TRAP_VEC),
  parameter bit              HALT_ON_TRAP = 1'b1,
  parameter int              CNT_W        = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [XLEN-1:0]             pc_i,
  input  logic                        stall_i,
  input  logic [N_FAULT-1:0]          fault_i,
  input  logic                        fault_ack_i,
  output logic [XLEN-1:0]             pc_o,
  output logic [XLEN-1:0]             epc_o,
  output logic [cause_w(N_FAULT)-1:0] cause_o,
  output logic                        trapped_o,
  output logic [CNT_W-1:0]            fault_cnt_o
);

  localparam int IDX_W = cause_w(N_FAULT);

  trap_state_e      state_q, state_n;
  logic [XLEN-1:0]  pc_q, pc_n;
  logic [XLEN-1:0]  epc_q, epc_n;
  logic [IDX_W-1:0] cause_q, cause_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic             fault_valid;
  logic [IDX_W-1:0] fault_idx;

  pc_fault_prio #(
    .N_FAULT (N_FAULT)
  ) u_prio (
    .fault (fault_i),
    .valid (fault_valid),
    .index (fault_idx)
  );

  // Next-state and next-register values for the RUN/TRAP controller.
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    epc_n   = epc_q;
    cause_n = cause_q;
    cnt_n   = cnt_q;

    unique case (state_q)
      RUN: begin
        // A fault wins over stall; fault_ack_i has no meaning here.
        if (fault_valid) begin
          state_n = TRAP;
          pc_n    = TRAP_VEC;
          epc_n   = pc_q;
          cause_n = fault_idx;
          cnt_n   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        end else if (!stall_i) begin
          pc_n = pc_i;
        end
      end

      TRAP: begin
        // No nesting: fault_i is not looked at until we are back in RUN.
        if (fault_ack_i) begin
          state_n = RUN;
          pc_n    = epc_q;
        end else if (HALT_ON_TRAP) begin
          pc_n = TRAP_VEC;
        end else if (!stall_i) begin
          pc_n = pc_i;
        end
      end

      default: begin
        state_n = RUN;
      end
    endcase
  end

  // State register with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      state_q <= RUN;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      cause_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      epc_q   <= epc_n;
      cause_q <= cause_n;
      cnt_q   <= cnt_n;
    end
  end

  assign pc_o        = pc_q;
  assign epc_o       = epc_q;
  assign cause_o     = cause_q;
  assign trapped_o   = (state_q == TRAP);
  assign fault_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_trap_unit.sv
// Bench for pc_trap_unit: two instances share stimulus, one halting in trap
// with an 8-bit counter, one running the handler with a 2-bit counter.
// A behavioural model of each is compared every cycle, and a directed
// sequence pins literal values before a randomized phase.
module tb_pc_trap_unit;

  localparam int XLEN = 32;
  localparam int NF   = 4;
  localparam logic [31:0] TV = 32'd248;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic [XLEN-1:0] pc_i = '0;
  logic            stall_i = 1'b0;
  logic [NF-1:0]   fault_i = '0;
  logic            fault_ack_i = 1'b0;

  logic [XLEN-1:0] pc_a, epc_a, pc_b, epc_b;
  logic [1:0]      cause_a, cause_b;
  logic            trap_a, trap_b;
  logic [7:0]      cnt_a;
  logic [1:0]      cnt_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pc_trap_unit #(.XLEN(XLEN), .N_FAULT(NF), .HALT_ON_TRAP(1'b1), .CNT_W(8)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i), .stall_i(stall_i),
    .fault_i(fault_i), .fault_ack_i(fault_ack_i),
    .pc_o(pc_a), .epc_o(epc_a), .cause_o(cause_a),
    .trapped_o(trap_a), .fault_cnt_o(cnt_a)
  );

  pc_trap_unit #(.XLEN(XLEN), .N_FAULT(NF), .HALT_ON_TRAP(1'b0), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i), .stall_i(stall_i),
    .fault_i(fault_i), .fault_ack_i(fault_ack_i),
    .pc_o(pc_b), .epc_o(epc_b), .cause_o(cause_b),
    .trapped_o(trap_b), .fault_cnt_o(cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) ----------
  bit          m_trap [2];
  int unsigned m_pc   [2];
  int unsigned m_epc  [2];
  int unsigned m_cause[2];
  int unsigned m_cnt  [2];
  bit          model_ok = 1'b0;

  const bit          halt_mode[2] = '{1'b1, 1'b0};
  const int unsigned cnt_max  [2] = '{255, 3};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_i) begin
        m_trap[k] = 0; m_pc[k] = 0; m_epc[k] = 0; m_cause[k] = 0; m_cnt[k] = 0;
      end else if (!m_trap[k]) begin
        if (fault_i != 0) begin
          int c = 0;
          for (int i = NF - 1; i >= 0; i--) if (fault_i[i]) c = i;
          m_epc[k]   = m_pc[k];
          m_pc[k]    = TV;
          m_cause[k] = c;
          if (m_cnt[k] < cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
          m_trap[k]  = 1;
        end else if (!stall_i) begin
          m_pc[k] = pc_i;
        end
      end else begin
        if (fault_ack_i) begin
          m_pc[k] = m_epc[k];
          m_trap[k] = 0;
        end else if (halt_mode[k]) begin
          m_pc[k] = TV;
        end else if (!stall_i) begin
          m_pc[k] = pc_i;
        end
      end
    end
    if (rst_i) model_ok = 1'b1;
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("a.pc",      pc_a,           m_pc[0]);
      check("a.epc",     epc_a,          m_epc[0]);
      check("a.cause",   32'(cause_a),   m_cause[0]);
      check("a.trapped", 32'(trap_a),    32'(m_trap[0]));
      check("a.cnt",     32'(cnt_a),     m_cnt[0]);
      check("b.pc",      pc_b,           m_pc[1]);
      check("b.epc",     epc_b,          m_epc[1]);
      check("b.cause",   32'(cause_b),   m_cause[1]);
      check("b.trapped", 32'(trap_b),    32'(m_trap[1]));
      check("b.cnt",     32'(cnt_b),     m_cnt[1]);
    end
  end

  // One clock edge has been applied when this returns.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // Reset then pc_i 4, 8 (stalled), 12.
    step();
    check("lit.rst.pc", pc_a, 0);
    check("lit.rst.trapped", 32'(trap_a), 0);
    check("lit.rst.cnt", 32'(cnt_a), 0);
    rst_i = 0; pc_i = 4;
    step(); check("lit.seq.pc4", pc_a, 4);
    pc_i = 8; stall_i = 1;
    step(); check("lit.seq.stall", pc_a, 4);
    pc_i = 12; stall_i = 0;
    step(); check("lit.seq.pc12", pc_a, 12);
    pc_i = 16;
    step(); check("lit.pc16", pc_a, 16);

    // Trap entry with two requests; lowest index wins, stall is overridden.
    fault_i = 4'b0110; pc_i = 20; stall_i = 1;
    step();
    check("lit.trap.pc", pc_a, 248);
    check("lit.trap.epc", epc_a, 16);
    check("lit.trap.cause", 32'(cause_a), 1);
    check("lit.trap.trapped", 32'(trap_a), 1);
    check("lit.trap.cnt", 32'(cnt_a), 1);
    check("lit.trap.b.pc", pc_b, 248);

    // In trap: faults ignored, halting instance frozen, other follows pc_i.
    fault_i = 4'b0001; stall_i = 0; pc_i = 252;
    step();
    check("lit.halt.pc", pc_a, 248);
    check("lit.halt.cause", 32'(cause_a), 1);
    check("lit.run.pc252", pc_b, 252);
    pc_i = 256;
    step();
    check("lit.run.pc256", pc_b, 256);
    check("lit.halt.pc2", pc_a, 248);
    pc_i = 300; stall_i = 1;
    step();
    check("lit.run.stall", pc_b, 256);
    check("lit.halt.stall", pc_a, 248);

    // Ack beats stall and fault in the same cycle.
    fault_ack_i = 1; pc_i = 400;
    step();
    check("lit.ack.a.pc", pc_a, 16);
    check("lit.ack.a.trapped", 32'(trap_a), 0);
    check("lit.ack.b.pc", pc_b, 16);
    check("lit.ack.b.trapped", 32'(trap_b), 0);

    // Persistent fault re-traps immediately after return.
    fault_ack_i = 0; stall_i = 0;
    step();
    check("lit.retrap.trapped", 32'(trap_a), 1);
    check("lit.retrap.cause", 32'(cause_a), 0);
    check("lit.retrap.epc", epc_a, 16);
    check("lit.retrap.b.cnt", 32'(cnt_b), 2);
    fault_i = 0; fault_ack_i = 1;
    step();
    check("lit.ret2.pc", pc_a, 16);
    check("lit.hold.cause", 32'(cause_a), 0);

    // Saturation of the 2-bit counter: 3 then 3; 8-bit counter keeps going.
    for (int k = 0; k < 2; k++) begin
      fault_i = 4'b0010; fault_ack_i = 0;
      step();
      check("lit.sat.b.cnt", 32'(cnt_b), 3);
      check("lit.sat.a.cnt", 32'(cnt_a), 32'(3 + k));
      fault_i = 0; fault_ack_i = 1;
      step();
    end

    // Reset mid-trap beats ack and fault.
    fault_i = 4'b0100; fault_ack_i = 0;
    step();
    check("lit.pre.rst.trapped", 32'(trap_a), 1);
    rst_i = 1; fault_ack_i = 1; fault_i = 4'b0001;
    step();
    check("lit.mrst.pc", pc_a, 0);
    check("lit.mrst.epc", epc_a, 0);
    check("lit.mrst.trapped", 32'(trap_a), 0);
    check("lit.mrst.cnt", 32'(cnt_a), 0);
    check("lit.mrst.b.trapped", 32'(trap_b), 0);

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      rst_i       = ($urandom_range(0, 99) < 2);
      pc_i        = $urandom;
      stall_i     = ($urandom_range(0, 99) < 30);
      fault_i     = ($urandom_range(0, 99) < 15) ? NF'($urandom) : '0;
      fault_ack_i = ($urandom_range(0, 99) < 25);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_trap_unit.md
PC_TRAP_UNIT -- requirements
Module: pc_trap_unit

Interface
REQ-001 Parameter XLEN, default 32, PC width in bits.
REQ-002 Parameter N_FAULT, default 4, number of fault request lines, >=1.
REQ-003 Parameter RESET_VEC, default 0, PC loaded on reset.
REQ-004 Parameter TRAP_VEC, default 248, PC loaded on trap entry.
REQ-005 Parameter HALT_ON_TRAP, default 1; 1 = PC frozen at TRAP_VEC while trapped, 0 = handler runs from TRAP_VEC.
REQ-006 Parameter CNT_W, default 8, fault counter width.
REQ-007 The block SHALL use one clock; reset is synchronous and active-high.
REQ-008 clk_i  in  1  clock, all state updates on rising edge.
REQ-009 rst_i  in  1  synchronous active-high reset.
REQ-010 pc_i  in  XLEN  next-PC candidate from fetch logic.
REQ-011 stall_i  in  1  hazard hold; PC keeps value.
REQ-012 fault_i  in  N_FAULT  level fault requests, bit 0 highest priority.
REQ-013 fault_ack_i  in  1  handler done; return from trap.
REQ-014 pc_o  out  XLEN  registered current PC.
REQ-015 epc_o  out  XLEN  saved PC of faulting instruction.
REQ-016 cause_o  out  max(1,clog2(N_FAULT))  index of fault taken.
REQ-017 trapped_o  out  1  high while in TRAP state.
REQ-018 fault_cnt_o  out  CNT_W  saturating count of traps taken.

Function
REQ-019 Two states SHALL exist: RUN, TRAP; trapped_o = (state == TRAP), registered.
REQ-020 RUN, no fault: next pc_o = stall_i ? pc_o : pc_i.
REQ-021 RUN, any fault_i bit high: next state TRAP, pc_o = TRAP_VEC, epc_o = current pc_o, cause_o = lowest set index, fault_cnt_o += 1; one-cycle latency.
REQ-022 Fault SHALL override stall_i in RUN.
REQ-023 fault_cnt_o SHALL saturate at 2^CNT_W-1, never wrap.
REQ-024 TRAP, HALT_ON_TRAP=1: pc_o SHALL hold TRAP_VEC regardless of pc_i and stall_i.
REQ-025 TRAP, HALT_ON_TRAP=0: next pc_o = stall_i ? pc_o : pc_i.
REQ-026 TRAP: fault_i SHALL be ignored; epc_o, cause_o, fault_cnt_o hold (no nesting).
REQ-027 TRAP with fault_ack_i high: next state RUN, pc_o = epc_o (retry faulting instruction); ack overrides stall_i and fault_i same cycle.
REQ-028 First RUN cycle after return SHALL sample fault_i again; persistent fault re-traps immediately.
REQ-029 fault_ack_i in RUN SHALL be ignored.
REQ-030 epc_o and cause_o SHALL hold last trap values after return until next trap.
REQ-031 PC arithmetic SHALL be XLEN bits; no internal increment or alignment check.

Reset
REQ-032 rst_i high at a clock edge SHALL set state RUN, pc_o = RESET_VEC, epc_o = 0, cause_o = 0, fault_cnt_o = 0, trapped_o = 0.
REQ-033 rst_i SHALL take priority over all inputs, including mid-trap and same-cycle fault_i/fault_ack_i.
REQ-034 Outputs SHALL not change between edges; no asynchronous path from rst_i.

Structure
REQ-035 Shared package SHALL hold state enum (RUN, TRAP) and default RESET_VEC/TRAP_VEC constants.
REQ-036 One sub-module pc_fault_prio (combinational priority encoder: fault_i -> valid, index) SHALL be instantiated; all state in pc_trap_unit.

Verification
REQ-037 Reset then pc_i = 4, 8, 12, stall_i on cycle 2 -> pc_o = 0, 4, 4, 12.
REQ-038 pc_o = 16, fault_i = 4'b0110 one cycle -> next pc_o = 248, epc_o = 16, cause_o = 1, trapped_o = 1, fault_cnt_o = 1.
REQ-039 HALT_ON_TRAP=1 in TRAP, pc_i varied, fault_i = 4'b0001 -> pc_o stays 248, cause_o stays 1; then fault_ack_i -> pc_o = 16, trapped_o = 0.
REQ-040 HALT_ON_TRAP=0 in TRAP, pc_i = 252, 256 -> pc_o follows; ack with stall_i and fault_i high -> pc_o = epc_o, state RUN.
REQ-041 CNT_W=2, four trap/ack cycles -> fault_cnt_o = 1, 2, 3, 3.
REQ-042 rst_i asserted in TRAP with fault_ack_i high -> pc_o = 0, epc_o = 0, trapped_o = 0, fault_cnt_o = 0.
